// File: rtl/issue_grant_pipeline.sv
// Registered grant pipeline behind issue-queue select: stage 1 feeds register read,
// stage DEPTH drives dependent wakeup and entry release. Supports flush and stall.
module issue_grant_pipeline #(
    parameter int ENTRY_NUM   = 16,
    parameter int ISSUE_WIDTH = 4,
    parameter int DEPTH       = 2,
    parameter int PTR_W       = $clog2(ENTRY_NUM),
    parameter int CNT_W       = $clog2(ISSUE_WIDTH*DEPTH+1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ISSUE_WIDTH-1:0]       sel_valid,
    input  logic [ISSUE_WIDTH*PTR_W-1:0] sel_ptr,
    input  logic                         stall,
    input  logic                         flush_all,
    input  logic [ENTRY_NUM-1:0]         flush_mask,
    output logic [ISSUE_WIDTH-1:0]       issue_valid,
    output logic [ISSUE_WIDTH*PTR_W-1:0] issue_ptr,
    output logic [ISSUE_WIDTH-1:0]       wakeup_valid,
    output logic [ISSUE_WIDTH*PTR_W-1:0] wakeup_ptr,
    output logic [ENTRY_NUM-1:0]         release_vector,
    output logic [CNT_W-1:0]             inflight_count
);

    typedef logic [ISSUE_WIDTH-1:0]            vld_t;
    typedef logic [ISSUE_WIDTH-1:0][PTR_W-1:0] ptrs_t;

    vld_t  stg_valid [DEPTH];
    ptrs_t stg_ptr   [DEPTH];
    vld_t  nxt_valid [DEPTH];
    ptrs_t nxt_ptr   [DEPTH];
    vld_t  stg_kill  [DEPTH];
    vld_t  sel_kill;
    ptrs_t sel_ptr_arr;
    logic [CNT_W-1:0] nxt_count;
    logic             dup_grant;

    assign sel_ptr_arr = sel_ptr;

    // Kill predicate evaluated for the incoming grants and for every held slot.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        sel_kill = '0;
        for (int k = 0; k < DEPTH; k++) stg_kill[k] = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            sel_kill[p] = flush_all | flush_mask[sel_ptr_arr[p]];
            for (int k = 0; k < DEPTH; k++)
                stg_kill[k][p] = flush_all | flush_mask[stg_ptr[k][p]];
        end
    end

    always_comb begin
        nxt_valid = stg_valid;
        nxt_ptr   = stg_ptr;
        if (stall) begin
            // Frozen stages still lose killed slots in place.
            for (int k = 0; k < DEPTH; k++)
                nxt_valid[k] = stg_valid[k] & ~stg_kill[k];
        end else begin
            nxt_valid[0] = sel_valid & ~sel_kill;
            nxt_ptr[0]   = sel_ptr_arr;
            for (int k = 1; k < DEPTH; k++) begin
                nxt_valid[k] = stg_valid[k-1] & ~stg_kill[k-1];
                nxt_ptr[k]   = stg_ptr[k-1];
            end
        end
    end

    // The count is simply the population of the post-update stages.
    always_comb begin
        int sum;
        sum = 0;
        for (int k = 0; k < DEPTH; k++)
            for (int p = 0; p < ISSUE_WIDTH; p++)
                sum = sum + int'(nxt_valid[k][p]);
        nxt_count = CNT_W'(sum);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all stages shift together.
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) stg_valid[k] <= '0;
            inflight_count <= '0;
        end else begin
            stg_valid      <= nxt_valid;
            inflight_count <= nxt_count;
        end
    end

    // NOTE: pointer storage is not reset; it is only ever observed through a valid bit.
    always_ff @(posedge clk) begin
        stg_ptr <= nxt_ptr;
    end

    assign issue_valid  = stg_valid[0] & {ISSUE_WIDTH{~stall}};
    assign issue_ptr    = stg_ptr[0];
    assign wakeup_valid = stg_valid[DEPTH-1] & {ISSUE_WIDTH{~stall}};
    assign wakeup_ptr   = stg_ptr[DEPTH-1];

    always_comb begin
        release_vector = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++)
            if (wakeup_valid[p]) release_vector[stg_ptr[DEPTH-1][p]] = 1'b1;
    end

    // Two ports granting the same entry in one cycle is an upstream select bug.
    always_comb begin
        dup_grant = 1'b0;
        for (int p = 0; p < ISSUE_WIDTH; p++)
            for (int q = p + 1; q < ISSUE_WIDTH; q++)
                if (sel_valid[p] && sel_valid[q] && sel_ptr_arr[p] == sel_ptr_arr[q])
                    dup_grant = 1'b1;
    end

    a_no_dup_grant: assert property (@(posedge clk) disable iff (rst) !dup_grant);

endmodule
